lsu_byte_sequencer: RTL and testbench

- Load/store unit between the execute stage (ALU address, rs2 data, funct3) and the byte-wide data memory (8-bit data, 16 entries by default).
- Breaks each RV32 load or store (byte, halfword or word) into sequential single-byte memory accesses, little-endian.
- Assembles and sign- or zero-extends load data.
- Reports misaligned or illegal requests without touching memory.

---
 rtl/lsu_pkg.sv | 17 +
 rtl/lsu_load_extend.sv | 17 +
 rtl/lsu_byte_sequencer.sv | 81 ++++++++
 tb/tb_lsu_byte_sequencer.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: funct3 codes, sequencer states and access-size decode shared by the load/store unit.
package lsu_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

    // 0 marks a funct3 that is not a load/store width at all
    function automatic logic [2:0] f3_bytes(input logic [2:0] f3);
        return (f3 == F3_B || f3 == F3_BU) ? 3'd1 :
               (f3 == F3_H || f3 == F3_HU) ? 3'd2 :
               (f3 == F3_W)                ? 3'd4 : 3'd0;
    endfunction
endpackage

// File: rtl/lsu_load_extend.sv
// lsu_load_extend: sign/zero-extends an assembled little-endian load word according to funct3.
module lsu_load_extend
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] word,
    output logic [XLEN-1:0] rdata
);
    always_comb begin
        rdata = (funct3 == F3_B)  ? {{(XLEN-8){word[7]}}, word[7:0]} :
                (funct3 == F3_H)  ? {{(XLEN-16){word[15]}}, word[15:0]} :
                (funct3 == F3_BU) ? {{(XLEN-8){1'b0}}, word[7:0]} :
                (funct3 == F3_HU) ? {{(XLEN-16){1'b0}}, word[15:0]} : word;
    end
endmodule

// File: rtl/lsu_byte_sequencer.sv
// lsu_byte_sequencer: splits RV32 loads/stores into little-endian single-byte memory accesses.
module lsu_byte_sequencer
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int XLEN   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_error,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);
    state_t state, state_nx;
    logic wr, err, legal_req, last;
    logic [2:0] f3, n_req, n;
    logic [ADDR_W-1:0] addr;
    logic [XLEN-1:0] wdata, word, ext;
    logic [1:0] idx;
    logic unused_addr;

    assign unused_addr = ^req_addr[XLEN-1:ADDR_W];
    assign n_req = f3_bytes(req_funct3);
    // n-1 doubles as the low-address alignment mask for sizes 1, 2 and 4
    assign legal_req = n_req != 3'd0 && !(req_write && req_funct3[2]) &&
                       (req_addr[1:0] & 2'(n_req - 3'd1)) == 2'b00;
    assign n = f3_bytes(f3);
    assign last = {1'b0, idx} == n - 3'd1;

    lsu_load_extend #(.XLEN(XLEN)) u_ext (.funct3(f3), .word(word), .rdata(ext));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx   = state == IDLE ? (req_valid ? (legal_req ? XFER : RESP) : IDLE) :
                     state == XFER ? (last ? RESP : XFER) : IDLE;
        req_ready  = state == IDLE;
        resp_valid = state == RESP;
        resp_error = state == RESP && err;
        resp_rdata = (state == RESP && !err && !wr) ? ext : '0;
        mem_we     = state == XFER && wr;
        mem_addr   = state == XFER ? addr + ADDR_W'(idx) : '0;
        mem_wdata  = (state == XFER && wr) ? wdata[8*idx +: 8] : 8'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr    <= 1'b0;
            err   <= 1'b0;
            f3    <= 3'd0;
            addr  <= '0;
            wdata <= '0;
            idx   <= 2'd0;
            word  <= '0;
        end else if (state == IDLE && req_valid) begin
            wr    <= req_write;
            err   <= !legal_req;
            f3    <= req_funct3;
            addr  <= req_addr[ADDR_W-1:0];
            wdata <= req_wdata;
            idx   <= 2'd0;
            word  <= '0;
        end else if (state == XFER) begin
            idx <= idx + 2'd1;
            if (!wr) word[8*idx +: 8] <= mem_rdata;
        end
    end
endmodule

// File: tb/tb_lsu_byte_sequencer.sv
// tb_lsu_byte_sequencer: random and directed load/store traffic checked against a byte-array reference model.
module tb_lsu_byte_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        resp_valid, resp_error, mem_we;
    logic [31:0] resp_rdata;
    logic [3:0]  mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic [7:0]  mem [16];
    logic [7:0]  ref_mem [16];
    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    lsu_byte_sequencer #(.ADDR_W(4), .XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_error(resp_error), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int nbytes(input bit w, input logic [2:0] f);
        if (w) return f == 0 ? 1 : f == 1 ? 2 : f == 2 ? 4 : 0;
        return (f == 0 || f == 4) ? 1 : (f == 1 || f == 5) ? 2 : f == 2 ? 4 : 0;
    endfunction

    task automatic run(input bit w, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] d, input bit hold);
        int n;
        bit e;
        int base;
        longint v;
        logic [31:0] expv;
        n = nbytes(w, f);
        e = n == 0 ? 1'b1 : (a % n) != 0;
        base = int'(a % 16);
        v = 0;
        if (!e && !w) begin
            for (int i = 0; i < n; i++) v += longint'(ref_mem[(base + i) % 16]) << (8 * i);
            if ((f == 0 || f == 1) && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
        end
        expv = v[31:0];
        @(negedge clk);
        check("ready_idle", req_ready, 1);
        req_valid = 1'b1; req_write = w; req_funct3 = f; req_addr = a; req_wdata = d;
        for (int c = 1; c <= (e ? 1 : n + 1); c++) begin
            @(negedge clk);
            if (!hold) req_valid = 1'b0;
            check("ready_busy", req_ready, 0);
            if (!e && c <= n) begin
                check("we", mem_we, w);
                check("addr", mem_addr, (base + c - 1) % 16);
                check("rv_early", resp_valid, 0);
                if (w) begin
                    check("wdata", mem_wdata, (d >> (8 * (c - 1))) & 32'hFF);
                    ref_mem[(base + c - 1) % 16] = d[8*(c-1) +: 8];
                end
            end else begin
                check("rv", resp_valid, 1);
                check("err", resp_error, e);
                check("rdata", resp_rdata, expv);
                check("we_resp", mem_we, 0);
            end
        end
        @(negedge clk);
        req_valid = 1'b0;
        check("rv_done", resp_valid, 0);
        check("ready_back", req_ready, 1);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem[i] = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        mem[4] = 8'h81; mem[5] = 8'h22; mem[6] = 8'h33; mem[7] = 8'h44;
        ref_mem[4] = 8'h81; ref_mem[5] = 8'h22; ref_mem[6] = 8'h33; ref_mem[7] = 8'h44;
        repeat (2) @(negedge clk);
        check("rst_ready", req_ready, 1);
        check("rst_rv", resp_valid, 0);
        check("rst_rdata", resp_rdata, 0);
        check("rst_err", resp_error, 0);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        rst_n = 1'b1;
        run(1, 3'b010, 32'h08, 32'hDEADBEEF, 0);
        run(0, 3'b010, 32'h04, 32'h0, 0);
        run(0, 3'b001, 32'h04, 32'h0, 0);
        run(0, 3'b101, 32'h06, 32'h0, 0);
        run(0, 3'b000, 32'h04, 32'h0, 0);
        run(0, 3'b100, 32'h04, 32'h0, 0);
        run(1, 3'b000, 32'h03, 32'h123456A5, 0);
        run(0, 3'b001, 32'h05, 32'h0, 0);
        run(1, 3'b010, 32'h0E, 32'h11111111, 0);
        run(0, 3'b011, 32'h00, 32'h0, 0);
        run(1, 3'b100, 32'h00, 32'h0, 0);
        run(0, 3'b010, 32'h1C, 32'h0, 1);
        // store abandoned by reset after its second byte has been written
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010; req_addr = 32'h08; req_wdata = 32'hCAFEF00D;
        @(negedge clk);
        req_valid = 1'b0;
        check("mr_addr0", mem_addr, 8);
        @(negedge clk);
        check("mr_addr1", mem_addr, 9);
        ref_mem[8] = 8'h0D; ref_mem[9] = 8'hF0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mr_ready", req_ready, 1);
        check("mr_we", mem_we, 0);
        check("mr_rv", resp_valid, 0);
        repeat (2) begin
            @(negedge clk);
            check("mr_rv_hold", resp_valid, 0);
            check("mr_we_hold", mem_we, 0);
        end
        rst_n = 1'b1;
        run(0, 3'b010, 32'h08, 32'h0, 0);
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a &= ~32'h3;
            run(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, 1'($urandom_range(0, 1)));
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
